// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, round count, S-box tables and GF(2^8) helpers.
// Used by both the encrypt and decrypt cores.
package aes_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_INIT_ARK,
        S_SB,
        S_SR,
        S_MC0,
        S_MC1,
        S_MC2,
        S_MC3,
        S_MC,
        S_ARK,
        S_DONE
    } aes_state_e;

    localparam int unsigned AES_NR     = 10;
    localparam logic [7:0]  RCON_START = 8'h01;

    // Row n of each table holds entries 16n..16n+15, entry 0 leftmost.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational MixColumns on one 32-bit column; row 0 byte in [31:24].
module aes_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;

    always_comb begin
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        mixed = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core with on-the-fly round-key generation.
// START/DONE handshake matches the decrypt core behind the Avalon register wrapper.
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter int unsigned NR        = AES_NR,
    parameter int unsigned MC_SERIAL = 1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         AES_START,
    output logic         AES_DONE,
    input  logic [127:0] AES_KEY,
    input  logic [127:0] AES_MSG_PT,
    output logic [127:0] AES_MSG_ENC
);

    localparam logic [3:0] NR_R = 4'(NR);

    aes_state_e   state, state_nxt;
    logic [127:0] st, rk;
    logic [7:0]   rcon;
    logic [3:0]   round;

    logic [127:0] st_sb, st_sr, mc_next, rk_next;
    logic [31:0]  sub_word;

    // Byte i of a 128-bit block sits at [127-8i -: 8]; state byte (r,c) is byte 4c+r.
    always_comb begin
        st_sb = '0;
        st_sr = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            st_sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                st_sr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        sub_word = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
        rk_next[127:96] = rk[127:96] ^ sub_word ^ {rcon, 24'h000000};
        rk_next[95:64]  = rk[95:64] ^ rk_next[127:96];
        rk_next[63:32]  = rk[63:32] ^ rk_next[95:64];
        rk_next[31:0]   = rk[31:0]  ^ rk_next[63:32];
    end

    generate
        if (MC_SERIAL != 0) begin : g_mc_serial
            logic [1:0]  mc_idx;
            logic [31:0] col, mixed;

            // One shared column unit; the MCk state selects which column it rewrites.
            always_comb begin
                case (state)
                    S_MC1:   mc_idx = 2'd1;
                    S_MC2:   mc_idx = 2'd2;
                    S_MC3:   mc_idx = 2'd3;
                    default: mc_idx = 2'd0;
                endcase
                col     = st[127-32*mc_idx -: 32];
                mc_next = st;
                mc_next[127-32*mc_idx -: 32] = mixed;
            end

            aes_mix_column u_mix (
                .col   (col),
                .mixed (mixed)
            );
        end else begin : g_mc_parallel
            for (genvar k = 0; k < 4; k++) begin : g_col
                aes_mix_column u_mix (
                    .col   (st[127-32*k -: 32]),
                    .mixed (mc_next[127-32*k -: 32])
                );
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:     state_nxt = AES_START ? S_LOAD : S_IDLE;
            S_LOAD:     state_nxt = S_INIT_ARK;
            S_INIT_ARK: state_nxt = S_SB;
            S_SB:       state_nxt = S_SR;
            S_SR: begin
                if (round == NR_R)       state_nxt = S_ARK;
                else if (MC_SERIAL != 0) state_nxt = S_MC0;
                else                     state_nxt = S_MC;
            end
            S_MC0:      state_nxt = S_MC1;
            S_MC1:      state_nxt = S_MC2;
            S_MC2:      state_nxt = S_MC3;
            S_MC3:      state_nxt = S_ARK;
            S_MC:       state_nxt = S_ARK;
            S_ARK:      state_nxt = (round == NR_R) ? S_DONE : S_SB;
            S_DONE:     state_nxt = AES_START ? S_DONE : S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            st    <= '0;
            rk    <= '0;
            rcon  <= '0;
            round <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    st    <= AES_MSG_PT;
                    rk    <= AES_KEY;
                    rcon  <= RCON_START;
                    round <= 4'd1;
                end
                S_INIT_ARK: st <= st ^ rk;
                S_SB:       st <= st_sb;
                S_SR: begin
                    st   <= st_sr;
                    rk   <= rk_next;
                    rcon <= xtime(rcon);
                end
                S_MC0, S_MC1, S_MC2, S_MC3, S_MC: st <= mc_next;
                S_ARK: begin
                    st <= st ^ rk;
                    if (round != NR_R) begin
                        round <= round + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        AES_DONE    = (state == S_DONE);
        AES_MSG_ENC = AES_DONE ? st : '0;
    end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core: FIPS-197 vectors, random vectors against a
// byte-array reference cipher, handshake, latency, reset-abort and input-capture behaviour.
module tb_aes_encrypt_core;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         AES_START;
    logic         AES_DONE;
    logic [127:0] AES_KEY;
    logic [127:0] AES_MSG_PT;
    logic [127:0] AES_MSG_ENC;

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;

    logic [7:0] ref_sbox [256];

    always #5 CLK = ~CLK;

    aes_encrypt_core #(
        .NR        (10),
        .MC_SERIAL (1)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .AES_START   (AES_START),
        .AES_DONE    (AES_DONE),
        .AES_KEY     (AES_KEY),
        .AES_MSG_PT  (AES_MSG_PT),
        .AES_MSG_ENC (AES_MSG_ENC)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] vv;
        vv = {v, v};
        return vv[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [176];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, x, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = key[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                x      = tmp[0];
                tmp[0] = ref_sbox[tmp[1]] ^ rc;
                tmp[1] = ref_sbox[tmp[2]];
                tmp[2] = ref_sbox[tmp[3]];
                tmp[3] = ref_sbox[x];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = ref_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the bench just after the edge that samples AES_START=1 in IDLE.
    task automatic start_run(input logic [127:0] key, input logic [127:0] pt);
        AES_KEY    = key;
        AES_MSG_PT = pt;
        AES_START  = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string tag, input int exp_edges);
        int edges;
        edges = 0;
        while (!AES_DONE && edges < 300) begin
            tick();
            edges++;
        end
        check({tag, "_latency"}, 128'(edges), 128'(exp_edges));
    endtask

    initial begin
        logic [127:0] k, p;
        int           drops, seen;

        build_sbox();
        RESET_N    = 1'b0;
        AES_START  = 1'b0;
        AES_KEY    = '0;
        AES_MSG_PT = '0;
        repeat (3) tick();
        check("reset_done", 128'(AES_DONE), 128'(0));
        check("reset_enc", AES_MSG_ENC, '0);
        RESET_N = 1'b1;
        tick();

        // FIPS-197 C.1 with a one-cycle START pulse
        start_run(K1, P1);
        AES_START = 1'b0;
        wait_done("c1", 68);
        check("c1_ct", AES_MSG_ENC, C1);
        tick();
        check("c1_done_one_cycle", 128'(AES_DONE), 128'(0));
        check("c1_enc_idle", AES_MSG_ENC, '0);

        // App. B with START held, then an asynchronous reset while in DONE
        start_run(KB, PB);
        wait_done("appb", 68);
        check("appb_ct", AES_MSG_ENC, CB);
        RESET_N = 1'b0;
        #2;
        check("async_rst_done", 128'(AES_DONE), 128'(0));
        check("async_rst_enc", AES_MSG_ENC, '0);
        AES_START = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();

        // Random vectors against the reference cipher
        for (int n = 0; n < 12; n++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_run(k, p);
            AES_START = 1'b0;
            wait_done($sformatf("rnd%0d", n), 68);
            check($sformatf("rnd%0d_ct", n), AES_MSG_ENC, ref_encrypt(k, p));
            tick();
        end

        // Inputs changed at edge 5 must not affect the result
        start_run(K1, P1);
        AES_START = 1'b0;
        repeat (5) tick();
        AES_KEY    = {$urandom(), $urandom(), $urandom(), $urandom()};
        AES_MSG_PT = {$urandom(), $urandom(), $urandom(), $urandom()};
        wait_done("late_change", 63);
        check("late_change_ct", AES_MSG_ENC, C1);
        tick();

        // Reset pulse at edge 30 aborts the run
        start_run(KB, PB);
        AES_START = 1'b0;
        repeat (30) tick();
        RESET_N = 1'b0;
        #1;
        check("abort_done", 128'(AES_DONE), 128'(0));
        check("abort_enc", AES_MSG_ENC, '0);
        tick();
        RESET_N = 1'b1;
        seen = 0;
        repeat (80) begin
            tick();
            if (AES_DONE) seen++;
        end
        check("abort_no_result", 128'(seen), 128'(0));
        start_run(K1, P1);
        AES_START = 1'b0;
        wait_done("after_abort", 68);
        check("after_abort_ct", AES_MSG_ENC, C1);
        tick();

        // START held for 200 cycles: one run, DONE held, then release and restart
        start_run(K1, P1);
        wait_done("held", 68);
        drops = 0;
        repeat (131) begin
            tick();
            if (!AES_DONE || AES_MSG_ENC !== C1) drops++;
        end
        check("held_stable", 128'(drops), 128'(0));
        check("held_ct", AES_MSG_ENC, C1);
        AES_START = 1'b0;
        tick();
        check("release_idle", 128'(AES_DONE), 128'(0));
        start_run(KB, PB);
        AES_START = 1'b0;
        wait_done("rerun", 68);
        check("rerun_ct", AES_MSG_ENC, CB);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
